// File: rtl/tm_pkg.sv
// Shared types and constants for the TM inference sequencer and its serial argmax.
// Pure declarations; no latency or flow control of its own.
package tm_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int SUM_W       = 32;
  localparam int CNT_W       = 17;
  localparam int IDX_W       = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    DRAIN,
    ARGMAX,
    RESULT
  } state_t;

  // Mux-style slice keeps every part-select constant after unrolling.
  function automatic logic signed [SUM_W-1:0] class_sum(
    input logic [NUM_CLASSES*SUM_W-1:0] sums,
    input logic [IDX_W-1:0]             idx
  );
    logic signed [SUM_W-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (idx == c[IDX_W-1:0]) r = sums[c*SUM_W +: SUM_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/tm_argmax_serial.sv
// Serial signed argmax, one class per cycle starting with the start pulse; done flags the last class
// with best_idx/best_sum already including it. No backpressure: sums must hold until done; flush cancels.
module tm_argmax_serial
  import tm_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         flush,
  input  logic [NUM_CLASSES*SUM_W-1:0] sums,
  output logic [IDX_W-1:0]             best_idx,
  output logic signed [SUM_W-1:0]      best_sum,
  output logic                         done
);

  logic [IDX_W-1:0]        cnt;
  logic                    run;
  logic [IDX_W-1:0]        idx_q;
  logic signed [SUM_W-1:0] sum_q;

  logic [IDX_W-1:0]        cur_idx;
  logic signed [SUM_W-1:0] cur_sum;
  logic                    active;
  logic                    take;

  always_comb begin
    cur_idx  = start ? '0 : cnt;
    cur_sum  = class_sum(sums, cur_idx);
    active   = (start || run) && !flush;
    // Strictly greater only, so ties stay with the earlier (lower) index.
    take     = start || (cur_sum > sum_q);
    best_idx = take ? cur_idx : idx_q;
    best_sum = take ? cur_sum : sum_q;
    done     = active && (cur_idx == IDX_W'(NUM_CLASSES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      run   <= 1'b0;
      idx_q <= '0;
      sum_q <= '0;
    end else if (flush) begin
      run <= 1'b0;
    end else if (active) begin
      idx_q <= best_idx;
      sum_q <= best_sum;
      cnt   <= cur_idx + 1'b1;
      run   <= !done;
    end
  end

endmodule

// File: rtl/tm_inference_sequencer.sv
// Per-sample TM inference: clear, clause/chunk sweep, drain, serial argmax; start-to-valid is 1+C*L+d+N+1.
// Result waits on pred_ready_i; start_i while busy is dropped, abort_i returns to IDLE with no result.
module tm_inference_sequencer
  import tm_pkg::*;
#(
  parameter int CLAUSES   = 2000,
  parameter int LA_CHUNKS = 49,
  parameter int DRAIN_MAX = 64
) (
  input  logic                         clk,
  input  logic                         rst_flag,
  input  logic                         start_i,
  input  logic                         abort_i,
  output logic [CNT_W-1:0]             clause_count,
  output logic [CNT_W-1:0]             la_chunk_count,
  output logic                         tm_rst_o,
  output logic                         tm_stop_o,
  input  logic                         tm_done_i,
  input  logic [NUM_CLASSES*SUM_W-1:0] class_sums_i,
  output logic                         pred_valid_o,
  input  logic                         pred_ready_i,
  output logic [3:0]                   pred_class_o,
  output logic [SUM_W-1:0]             pred_sum_o,
  output logic                         busy_o,
  output logic                         timeout_o
);

  localparam int DW = $clog2(DRAIN_MAX + 1);

  state_t          state;
  logic [DW-1:0]   drain_cnt;
  logic            argmax_start;

  logic            chunk_wrap;
  logic            scan_last;
  logic            nxt_last;
  logic [CNT_W-1:0] nxt_chunk;
  logic [CNT_W-1:0] nxt_clause;

  logic                    am_flush;
  logic                    am_done;
  logic [IDX_W-1:0]        am_idx;
  logic signed [SUM_W-1:0] am_sum;

  always_comb begin
    chunk_wrap = (la_chunk_count == CNT_W'(LA_CHUNKS - 1));
    nxt_chunk  = chunk_wrap ? '0 : la_chunk_count + 1'b1;
    nxt_clause = chunk_wrap ? clause_count + 1'b1 : clause_count;
    scan_last  = chunk_wrap && (clause_count == CNT_W'(CLAUSES - 1));
    // tm_stop_o is registered, so it is raised one step ahead of the last pair.
    nxt_last   = (nxt_clause == CNT_W'(CLAUSES - 1)) && (nxt_chunk == CNT_W'(LA_CHUNKS - 1));
    am_flush   = abort_i && (state != IDLE);
  end

  tm_argmax_serial u_argmax (
    .clk      (clk),
    .rst      (rst_flag),
    .start    (argmax_start),
    .flush    (am_flush),
    .sums     (class_sums_i),
    .best_idx (am_idx),
    .best_sum (am_sum),
    .done     (am_done)
  );

  always_ff @(posedge clk or posedge rst_flag) begin
    if (rst_flag) begin
      state          <= IDLE;
      clause_count   <= '0;
      la_chunk_count <= '0;
      drain_cnt      <= '0;
      argmax_start   <= 1'b0;
      tm_rst_o       <= 1'b0;
      tm_stop_o      <= 1'b0;
      pred_valid_o   <= 1'b0;
      pred_class_o   <= '0;
      pred_sum_o     <= '0;
      busy_o         <= 1'b0;
      timeout_o      <= 1'b0;
    end else if (abort_i && (state != IDLE)) begin
      state        <= IDLE;
      argmax_start <= 1'b0;
      tm_rst_o     <= 1'b0;
      tm_stop_o    <= 1'b0;
      pred_valid_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state          <= CLEAR;
            busy_o         <= 1'b1;
            tm_rst_o       <= 1'b1;
            timeout_o      <= 1'b0;
            clause_count   <= '0;
            la_chunk_count <= '0;
          end
        end
        CLEAR: begin
          state     <= SCAN;
          tm_rst_o  <= 1'b0;
          tm_stop_o <= (CLAUSES == 1) && (LA_CHUNKS == 1);
        end
        SCAN: begin
          if (scan_last) begin
            state     <= DRAIN;
            tm_stop_o <= 1'b0;
            drain_cnt <= '0;
          end else begin
            clause_count   <= nxt_clause;
            la_chunk_count <= nxt_chunk;
            tm_stop_o      <= nxt_last;
          end
        end
        DRAIN: begin
          if (tm_done_i) begin
            state        <= ARGMAX;
            argmax_start <= 1'b1;
          end else if (drain_cnt == DW'(DRAIN_MAX - 1)) begin
            state        <= ARGMAX;
            argmax_start <= 1'b1;
            timeout_o    <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ARGMAX: begin
          argmax_start <= 1'b0;
          if (am_done) begin
            state        <= RESULT;
            pred_valid_o <= 1'b1;
            pred_class_o <= am_idx;
            pred_sum_o   <= am_sum;
          end
        end
        RESULT: begin
          if (pred_ready_i) begin
            state        <= IDLE;
            pred_valid_o <= 1'b0;
            busy_o       <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm_inference_sequencer.sv
// Directed bench for tm_inference_sequencer with a 3x2 sweep, 10 classes and an 8-cycle drain limit.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_tm_inference_sequencer;

  localparam int CL = 3;
  localparam int LC = 2;
  localparam int NC = 10;
  localparam int SW = 32;
  localparam int CW = 17;
  localparam int DM = 8;

  logic            clk;
  logic            rst_flag;
  logic            start_i;
  logic            abort_i;
  logic [CW-1:0]   clause_count;
  logic [CW-1:0]   la_chunk_count;
  logic            tm_rst_o;
  logic            tm_stop_o;
  logic            tm_done_i;
  logic [NC*SW-1:0] class_sums_i;
  logic            pred_valid_o;
  logic            pred_ready_i;
  logic [3:0]      pred_class_o;
  logic [SW-1:0]   pred_sum_o;
  logic            busy_o;
  logic            timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  tm_inference_sequencer #(.CLAUSES(CL), .LA_CHUNKS(LC), .DRAIN_MAX(DM)) dut (
    .clk            (clk),
    .rst_flag       (rst_flag),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .clause_count   (clause_count),
    .la_chunk_count (la_chunk_count),
    .tm_rst_o       (tm_rst_o),
    .tm_stop_o      (tm_stop_o),
    .tm_done_i      (tm_done_i),
    .class_sums_i   (class_sums_i),
    .pred_valid_o   (pred_valid_o),
    .pred_ready_i   (pred_ready_i),
    .pred_class_o   (pred_class_o),
    .pred_sum_o     (pred_sum_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < NC; i++) class_sums_i[i*SW +: SW] = v;
  endtask

  task automatic set_one(input int idx, input int v);
    class_sums_i[idx*SW +: SW] = v;
  endtask

  // Start a run and wait for pred_valid_o; tm_done_i is high from cycle done_at on (0 = never).
  task automatic do_run(input int done_at, output int lat);
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    lat = 1;
    while (!pred_valid_o && lat < 100) begin
      tm_done_i = (done_at > 0) && (lat >= done_at);
      tick;
      lat++;
    end
    tm_done_i = 1'b0;
  endtask

  task automatic finish_xfer;
    pred_ready_i = 1'b1;
    tick;
    pred_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_flag = 1'b1;
    repeat (2) tick;
    n_checks++;
    if ({busy_o, pred_valid_o, tm_rst_o, tm_stop_o, timeout_o, pred_class_o, pred_sum_o,
         clause_count, la_chunk_count} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got busy=%b valid=%b rst=%b stop=%b to=%b cls=%0d sum=%0d cl=%0d ch=%0d, want all 0",
               busy_o, pred_valid_o, tm_rst_o, tm_stop_o, timeout_o, pred_class_o, pred_sum_o,
               clause_count, la_chunk_count);
    end
    rst_flag = 1'b0;
    tick;
    n_checks++;
    if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_idle: busy got %b want 0", busy_o); end
  endtask

  task automatic test_sweep_latency;
    int n;
    for (int i = 0; i < NC; i++) set_one(i, 3 * i - 10);
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    n = 1;
    n_checks++;
    if ({tm_rst_o, busy_o, tm_stop_o} !== 3'b110 || clause_count !== '0 || la_chunk_count !== '0) begin
      n_errors++;
      $display("FAIL clear_cycle: got rst=%b busy=%b stop=%b pair=(%0d,%0d) want rst=1 busy=1 stop=0 (0,0)",
               tm_rst_o, busy_o, tm_stop_o, clause_count, la_chunk_count);
    end
    for (int k = 0; k < CL * LC; k++) begin
      tick;
      n++;
      n_checks++;
      if (clause_count !== CW'(k / LC) || la_chunk_count !== CW'(k % LC) ||
          tm_stop_o !== (k == CL * LC - 1) || tm_rst_o !== 1'b0) begin
        n_errors++;
        $display("FAIL sweep_pair%0d: got (%0d,%0d) stop=%b rst=%b want (%0d,%0d) stop=%b rst=0",
                 k, clause_count, la_chunk_count, tm_stop_o, tm_rst_o, k / LC, k % LC, k == CL * LC - 1);
      end
    end
    while (!pred_valid_o && n < 100) begin
      tm_done_i = (n >= 9);
      tick;
      n++;
      if (n == 8) begin
        n_checks++;
        if (tm_stop_o !== 1'b0 || clause_count !== CW'(2) || la_chunk_count !== CW'(1)) begin
          n_errors++;
          $display("FAIL drain_hold: got stop=%b pair=(%0d,%0d) want stop=0 (2,1)",
                   tm_stop_o, clause_count, la_chunk_count);
        end
      end
    end
    tm_done_i = 1'b0;
    n_checks++;
    if (n !== 20) begin n_errors++; $display("FAIL latency: got %0d want 20", n); end
    n_checks++;
    if (pred_class_o !== 4'd9 || $signed(pred_sum_o) !== 17 || timeout_o !== 1'b0) begin
      n_errors++;
      $display("FAIL sweep_result: got cls=%0d sum=%0d to=%b want cls=9 sum=17 to=0",
               pred_class_o, $signed(pred_sum_o), timeout_o);
    end
    finish_xfer;
    n_checks++;
    if (pred_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL sweep_release: got valid=%b busy=%b want 0 0", pred_valid_o, busy_o);
    end
  endtask

  task automatic test_argmax;
    int lat;
    int exp_cls;
    int exp_sum;
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin set_all(-5); set_one(7, 12); exp_cls = 7; exp_sum = 12; end
        1: begin set_all(0); set_one(3, 9); set_one(8, 9); exp_cls = 3; exp_sum = 9; end
        2: begin
             for (int i = 0; i < NC; i++) set_one(i, -100 * (i + 1));
             exp_cls = 0; exp_sum = -100;
           end
        3: begin
             set_all(0); set_one(0, 32'sh8000_0000); set_one(9, 32'sh7fff_ffff);
             exp_cls = 9; exp_sum = 32'sh7fff_ffff;
           end
        default: begin set_all(4); exp_cls = 0; exp_sum = 4; end
      endcase
      do_run(9, lat);
      n_checks++;
      if (lat !== 20 || pred_class_o !== 4'(exp_cls) || $signed(pred_sum_o) !== exp_sum) begin
        n_errors++;
        $display("FAIL argmax_case%0d: got lat=%0d cls=%0d sum=%0d want lat=20 cls=%0d sum=%0d",
                 c, lat, pred_class_o, $signed(pred_sum_o), exp_cls, exp_sum);
      end
      finish_xfer;
    end
  endtask

  task automatic test_drain_entry;
    int lat;
    set_all(0);
    set_one(2, 1);
    do_run(8, lat);
    n_checks++;
    if (lat !== 19 || pred_class_o !== 4'd2 || timeout_o !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_entry: got lat=%0d cls=%0d to=%b want lat=19 cls=2 to=0", lat, pred_class_o, timeout_o);
    end
    finish_xfer;
  endtask

  task automatic test_timeout;
    int lat;
    set_all(1);
    do_run(0, lat);
    n_checks++;
    if (lat !== 26 || timeout_o !== 1'b1 || pred_class_o !== 4'd0 || $signed(pred_sum_o) !== 1) begin
      n_errors++;
      $display("FAIL timeout_run: got lat=%0d to=%b cls=%0d sum=%0d want lat=26 to=1 cls=0 sum=1",
               lat, timeout_o, pred_class_o, $signed(pred_sum_o));
    end
    finish_xfer;
    n_checks++;
    if (timeout_o !== 1'b1 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_sticky: got to=%b busy=%b want to=1 busy=0", timeout_o, busy_o);
    end
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    n_checks++;
    if (timeout_o !== 1'b0 || tm_rst_o !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_clear: got to=%b rst=%b want to=0 rst=1", timeout_o, tm_rst_o);
    end
    abort_i = 1'b1;
    tick;
    abort_i = 1'b0;
  endtask

  task automatic test_back_to_back_hold;
    int lat;
    set_all(0);
    set_one(5, 50);
    do_run(9, lat);
    n_checks++;
    if (lat !== 20) begin n_errors++; $display("FAIL hold_latency: got %0d want 20", lat); end
    for (int k = 0; k < 5; k++) begin
      start_i = (k == 2);
      tick;
      start_i = 1'b0;
      n_checks++;
      if (pred_valid_o !== 1'b1 || pred_class_o !== 4'd5 || $signed(pred_sum_o) !== 50 ||
          busy_o !== 1'b1 || tm_rst_o !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_cycle%0d: got valid=%b cls=%0d sum=%0d busy=%b rst=%b want 1 5 50 1 0",
                 k, pred_valid_o, pred_class_o, $signed(pred_sum_o), busy_o, tm_rst_o);
      end
    end
    pred_ready_i = 1'b1;
    start_i = 1'b1;
    tick;
    pred_ready_i = 1'b0;
    start_i = 1'b0;
    n_checks++;
    if (pred_valid_o !== 1'b0 || busy_o !== 1'b0 || tm_rst_o !== 1'b0 ||
        pred_class_o !== 4'd5 || $signed(pred_sum_o) !== 50) begin
      n_errors++;
      $display("FAIL hold_xfer: got valid=%b busy=%b rst=%b cls=%0d sum=%0d want 0 0 0 5 50",
               pred_valid_o, busy_o, tm_rst_o, pred_class_o, $signed(pred_sum_o));
    end
    tick;
    n_checks++;
    if (busy_o !== 1'b0 || tm_rst_o !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_noqueue: got busy=%b rst=%b want 0 0", busy_o, tm_rst_o);
    end
  endtask

  task automatic test_abort_reset;
    int n;
    int seen;
    // Abort in the middle of the sweep.
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    repeat (3) tick;
    abort_i = 1'b1;
    tick;
    abort_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || pred_valid_o !== 1'b0 || tm_stop_o !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_scan: got busy=%b valid=%b stop=%b want 0 0 0", busy_o, pred_valid_o, tm_stop_o);
    end
    seen = 0;
    tm_done_i = 1'b1;
    repeat (30) begin tick; if (pred_valid_o) seen++; end
    tm_done_i = 1'b0;
    n_checks++;
    if (seen !== 0) begin n_errors++; $display("FAIL abort_scan_result: valid cycles got %0d want 0", seen); end

    // Abort coinciding with the stop strobe.
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    repeat (6) tick;
    n_checks++;
    if (tm_stop_o !== 1'b1) begin n_errors++; $display("FAIL abort_stop_setup: stop got %b want 1", tm_stop_o); end
    abort_i = 1'b1;
    tm_done_i = 1'b1;
    tick;
    abort_i = 1'b0;
    seen = 0;
    repeat (25) begin tick; if (pred_valid_o || busy_o) seen++; end
    tm_done_i = 1'b0;
    n_checks++;
    if (seen !== 0) begin n_errors++; $display("FAIL abort_stop: busy/valid cycles got %0d want 0", seen); end

    // Asynchronous reset while ARGMAX is running.
    set_all(0);
    set_one(6, 3);
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    n = 1;
    while (n < 12) begin
      tm_done_i = (n >= 9);
      tick;
      n++;
    end
    tm_done_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b1 || pred_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL argmax_busy: got busy=%b valid=%b want 1 0", busy_o, pred_valid_o);
    end
    #1 rst_flag = 1'b1;
    #1;
    n_checks++;
    if ({busy_o, pred_valid_o, tm_rst_o, tm_stop_o, timeout_o, pred_class_o, pred_sum_o,
         clause_count, la_chunk_count} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got busy=%b valid=%b cls=%0d sum=%0d cl=%0d ch=%0d want all 0",
               busy_o, pred_valid_o, pred_class_o, pred_sum_o, clause_count, la_chunk_count);
    end
    tick;
    rst_flag = 1'b0;
    seen = 0;
    repeat (20) begin tick; if (pred_valid_o || busy_o) seen++; end
    n_checks++;
    if (seen !== 0) begin n_errors++; $display("FAIL reset_quiet: busy/valid cycles got %0d want 0", seen); end
  endtask

  initial begin
    rst_flag     = 1'b1;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    tm_done_i    = 1'b0;
    pred_ready_i = 1'b0;
    class_sums_i = '0;
    test_reset;
    test_sweep_latency;
    test_argmax;
    test_drain_entry;
    test_timeout;
    test_back_to_back_hold;
    test_abort_reset;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
